// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Elastic registered retiming buffer: WIDTH-bit words through DEPTH stages.
// Optional COUNT port under GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN.
module gf180mcu_fd_sc_mcu7t5v0__bufpipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] Z,
  output logic             Z_VALID,
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
`endif
  input  logic             Z_READY
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;

  // Ready ripples back from the output; a bubble anywhere downstream frees k.
  always_comb begin
    logic a;
    adv = '0;
    a = v[DEPTH-1] ? Z_READY : 1'b1;
    adv[DEPTH-1] = a;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      a = !v[k+1] || a;
      adv[k] = a;
    end
  end

  assign I_READY = adv[0];
  assign Z       = d[DEPTH-1];
  assign Z_VALID = v[DEPTH-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= I_VALID;
        if (I_VALID) begin
          d[0] <= I;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            d[k] <= d[k-1];
          end
        end
      end
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic push;
  logic pop;

  assign push = I_VALID && I_READY;
  assign pop  = Z_VALID && Z_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   COUNT <= COUNT + CW'(1);
        2'b01:   COUNT <= COUNT - CW'(1);
        default: COUNT <= COUNT;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Bench for the elastic retiming buffer, WIDTH=8 DEPTH=3.
// Define GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN to also check COUNT.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] I = 8'h00;
  logic       I_VALID = 1'b0;
  logic       I_READY;
  logic [7:0] Z;
  logic       Z_VALID;
  logic       Z_READY = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN
  logic [1:0] COUNT;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [$];

  gf180mcu_fd_sc_mcu7t5v0__bufpipe #(
    .WIDTH(8),
    .DEPTH(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .I(I),
    .I_VALID(I_VALID),
    .I_READY(I_READY),
    .Z(Z),
    .Z_VALID(Z_VALID),
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN
    .COUNT(COUNT),
`endif
    .Z_READY(Z_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int exp);
`ifdef GF180MCU_FD_SC_MCU7T5V0__BUFPIPE_COUNT_EN
    chk(name, 32'(COUNT), 32'(exp));
`else
    if (exp < 0) $display("bad count arg %s", name);
`endif
  endtask

  // Inputs change 1 time unit after the rising edge; caller checks at negedge.
  task automatic step(input logic rst, input logic iv,
                      input logic [7:0] i, input logic zr);
    @(posedge CLK);
    #1;
    RST = rst;
    I_VALID = iv;
    I = i;
    Z_READY = zr;
    @(negedge CLK);
  endtask

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
    end else begin
      if (Z_VALID && Z_READY) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_spurious actual=%h expected=none", Z);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (Z !== e) begin
            failures++;
            $display("FAIL sb_order actual=%h expected=%h", Z, e);
          end
        end
      end
      if (I_VALID && I_READY) sb.push_back(I);
    end
  end

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] i;
    logic       zr;
    logic       ck;
    logic       ckz;
    logic       ir;
    logic       zv;
    logic [7:0] z;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // reset with a word offered, then single-word latency
    tbl[0] = '{1, 1, 8'hAA, 1, 0, 0, 1, 0, 8'h00};
    tbl[1] = '{1, 1, 8'hAA, 1, 1, 1, 1, 0, 8'h00};
    tbl[2] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00};
    tbl[3] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00};
    tbl[4] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h00};
    tbl[5] = '{0, 1, 8'h5A, 1, 1, 1, 1, 0, 8'h00};
    tbl[6] = '{0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00};
    tbl[7] = '{0, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00};
    tbl[8] = '{0, 0, 8'h00, 1, 1, 1, 1, 1, 8'h5A};
    tbl[9] = '{0, 0, 8'h00, 1, 1, 1, 1, 0, 8'h5A};

    for (int r = 0; r < 10; r++) begin
      step(tbl[r].rst, tbl[r].iv, tbl[r].i, tbl[r].zr);
      if (tbl[r].ck) begin
        chk($sformatf("tbl%0d_ir", r), 32'(I_READY), 32'(tbl[r].ir));
        chk($sformatf("tbl%0d_zv", r), 32'(Z_VALID), 32'(tbl[r].zv));
        if (tbl[r].ckz)
          chk($sformatf("tbl%0d_z", r), 32'(Z), 32'(tbl[r].z));
      end
      if (r == 2) chk_cnt("rst_count", 0);
    end

    // streaming: one word per cycle, no gaps
    for (int c = 0; c < 19; c++) begin
      step(0, c < 16, 8'(c + 1), 1);
      if (c < 16) chk($sformatf("str%0d_ir", c), 32'(I_READY), 1);
      chk($sformatf("str%0d_zv", c), 32'(Z_VALID), 32'(c >= 3));
      if (c >= 3) chk($sformatf("str%0d_z", c), 32'(Z), 32'(c - 2));
    end
    step(0, 0, 8'h00, 1);
    chk("str_drained", 32'(Z_VALID), 0);

    // backpressure fill
    step(0, 1, 8'h11, 0);
    chk("bp_ir0", 32'(I_READY), 1);
    step(0, 1, 8'h22, 0);
    chk("bp_ir1", 32'(I_READY), 1);
    step(0, 1, 8'h33, 0);
    chk("bp_ir2", 32'(I_READY), 1);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 8'h44, 0);
      chk("bp_full_ir", 32'(I_READY), 0);
      chk("bp_full_zv", 32'(Z_VALID), 1);
      chk("bp_full_z", 32'(Z), 32'h11);
      chk_cnt("bp_full_count", 3);
    end
    step(0, 0, 8'h00, 0);
    chk("bp_ir_no_iv", 32'(I_READY), 0);

    // full with simultaneous pop and push
    step(0, 1, 8'h44, 1);
    chk("pp_ir", 32'(I_READY), 1);
    chk("pp_z", 32'(Z), 32'h11);
    step(0, 0, 8'h00, 0);
    chk("pp_z_next", 32'(Z), 32'h22);
    chk("pp_ir_next", 32'(I_READY), 0);
    chk_cnt("pp_count", 3);
    for (int c = 0; c < 3; c++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("pp_drained", 32'(Z_VALID), 0);
    chk_cnt("pp_count_empty", 0);

    // mid-operation reset on a full block
    step(0, 1, 8'h61, 0);
    step(0, 1, 8'h62, 0);
    step(0, 1, 8'h63, 0);
    step(0, 1, 8'h64, 0);
    chk("mr_full", 32'(I_READY), 0);
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h77, 1);
    chk("mr_zv", 32'(Z_VALID), 0);
    chk("mr_ir", 32'(I_READY), 1);
    chk("mr_z", 32'(Z), 32'h00);
    chk_cnt("mr_count", 0);
    step(0, 0, 8'h00, 1);
    chk("mr_stale1", 32'(Z_VALID), 0);
    step(0, 0, 8'h00, 1);
    chk("mr_stale2", 32'(Z_VALID), 0);
    step(0, 0, 8'h00, 1);
    chk("mr_zv3", 32'(Z_VALID), 1);
    chk("mr_z3", 32'(Z), 32'h77);
    step(0, 0, 8'h00, 1);
    chk("mr_once", 32'(Z_VALID), 0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
